// File: rtl/gpr_wb_arbiter.sv
// rtl/gpr_wb_arbiter.sv - GPR write-port arbiter with mul/div result FIFO and busy scoreboard
//
// Shares the single GPR write port between the WB stage and buffered
// multiply/divide results. A starvation counter guarantees that a buffered
// head is written within STARVE_LIMIT+1 cycles, even under back-to-back
// pipeline writes. A 32-entry busy scoreboard flags hazards to decode for
// registers whose mul/div result has not yet reached the GPR.
module gpr_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        Reset,

  input  logic        pipe_wr,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic [31:0] pipe_pc,
  output logic        pipe_stall,

  input  logic        md_issue,
  input  logic [4:0]  md_issue_rd,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  input  logic [31:0] md_pc,

  input  logic [4:0]  dec_rs,
  input  logic [4:0]  dec_rt,
  output logic        hazard,

  output logic        gpr_WR,
  output logic [4:0]  gpr_mod_reg,
  output logic [31:0] gpr_in_data,
  output logic [31:0] gpr_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SC_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [SC_W-1:0]  LIMIT_C  = SC_W'(STARVE_LIMIT);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  // Result FIFO storage (data path only, never needs reset)
  logic [4:0]       r_fifo_rd   [DEPTH];
  logic [31:0]      r_fifo_data [DEPTH];
  logic [31:0]      r_fifo_pc   [DEPTH];

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [SC_W-1:0]  r_starve;
  logic [31:0]      r_busy;

  logic             w_push;
  logic             w_pop;
  logic             w_fifo_ne;
  logic             w_force;
  logic             w_head_grant;
  logic             w_pipe_grant;
  logic [4:0]       w_head_rd;
  logic [31:0]      w_head_data;
  logic [31:0]      w_head_pc;
  logic [31:0]      w_busy_nxt;

  // Ring pointer advance; DEPTH need not be a power of two
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign w_fifo_ne   = (r_count != '0);
  assign w_head_rd   = r_fifo_rd[r_head];
  assign w_head_data = r_fifo_data[r_head];
  assign w_head_pc   = r_fifo_pc[r_head];

  // A full FIFO refuses a result even if it pops this cycle: keeps md_ready
  // independent of the arbitration outcome.
  assign md_ready = (r_count < DEPTH_C) && !Reset;
  assign w_push   = md_valid && md_ready;

  // A starved head overrides the pipeline and holds its write.
  assign w_force      = w_fifo_ne && (r_starve == LIMIT_C) && !Reset;
  assign w_head_grant = w_force || (!pipe_wr && w_fifo_ne && !Reset);
  assign w_pipe_grant = !w_force && pipe_wr && !Reset;
  assign w_pop        = w_head_grant;
  assign pipe_stall   = w_force;

  // Winner drives the GPR write port combinationally; $0 writes are suppressed
  always_comb begin
    gpr_WR      = 1'b0;
    gpr_mod_reg = 5'd0;
    gpr_in_data = 32'd0;
    gpr_pc      = 32'd0;
    if (w_head_grant) begin
      gpr_WR      = (w_head_rd != 5'd0);
      gpr_mod_reg = w_head_rd;
      gpr_in_data = w_head_data;
      gpr_pc      = w_head_pc;
    end else if (w_pipe_grant) begin
      gpr_WR      = (pipe_rd != 5'd0);
      gpr_mod_reg = pipe_rd;
      gpr_in_data = pipe_data;
      gpr_pc      = pipe_pc;
    end
  end

  // Capture accepted mul/div results at the tail slot
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_tail]   <= md_rd;
      r_fifo_data[r_tail] <= md_data;
      r_fifo_pc[r_tail]   <= md_pc;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= ptr_inc(r_tail);
      if (w_pop)  r_head <= ptr_inc(r_head);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Count consecutive lost arbitrations of the current head, saturating
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_starve <= '0;
    end else if (!w_fifo_ne || w_head_grant) begin
      r_starve <= '0;
    end else if (r_starve != LIMIT_C) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  // Next busy vector: a new issue to the same register outranks the clear
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_head_grant) w_busy_nxt[w_head_rd] = 1'b0;
    if (md_issue)     w_busy_nxt[md_issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign hazard = r_busy[dec_rs] | r_busy[dec_rt] | (md_issue & r_busy[md_issue_rd]);

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb/tb_gpr_wb_arbiter.sv - self-checking bench for gpr_wb_arbiter
module tb_gpr_wb_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 3;

  logic        clk = 1'b0;
  logic        Reset;
  logic        pipe_wr;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic [31:0] pipe_pc;
  logic        pipe_stall;
  logic        md_issue;
  logic [4:0]  md_issue_rd;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic [31:0] md_pc;
  logic [4:0]  dec_rs;
  logic [4:0]  dec_rt;
  logic        hazard;
  logic        gpr_WR;
  logic [4:0]  gpr_mod_reg;
  logic [31:0] gpr_in_data;
  logic [31:0] gpr_pc;

  gpr_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .Reset(Reset),
    .pipe_wr(pipe_wr), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_pc(pipe_pc),
    .pipe_stall(pipe_stall),
    .md_issue(md_issue), .md_issue_rd(md_issue_rd),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data), .md_pc(md_pc),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .hazard(hazard),
    .gpr_WR(gpr_WR), .gpr_mod_reg(gpr_mod_reg), .gpr_in_data(gpr_in_data), .gpr_pc(gpr_pc)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  bit          busy [32];
  int          starve = 0;
  bit          e_ready, e_force, e_head, e_pipe, e_wr, e_haz;
  logic [4:0]  e_rd;
  logic [31:0] e_data, e_pc;

  // Every negedge: predict outputs from queue/busy state, compare, then advance
  always @(negedge clk) begin
    if (Reset) begin
      q.delete();
      foreach (busy[i]) busy[i] = 0;
      starve = 0;
      chk("rst_md_ready", md_ready, 0);
      chk("rst_gpr_WR", gpr_WR, 0);
      chk("rst_mod_reg", gpr_mod_reg, 0);
      chk("rst_in_data", gpr_in_data, 0);
      chk("rst_gpr_pc", gpr_pc, 0);
      chk("rst_stall", pipe_stall, 0);
      chk("rst_hazard", hazard, 0);
    end else begin
      e_ready = (q.size() < DEPTH);
      e_force = (q.size() > 0) && (starve == STARVE_LIMIT);
      e_head  = e_force || (!pipe_wr && q.size() > 0);
      e_pipe  = !e_force && pipe_wr;
      e_rd = 0; e_data = 0; e_pc = 0;
      if (e_head) begin
        e_rd = q[0].rd; e_data = q[0].data; e_pc = q[0].pc;
      end else if (e_pipe) begin
        e_rd = pipe_rd; e_data = pipe_data; e_pc = pipe_pc;
      end
      e_wr  = (e_head || e_pipe) && (e_rd != 0);
      e_haz = busy[dec_rs] || busy[dec_rt] || (md_issue && busy[md_issue_rd]);

      chk("md_ready", md_ready, e_ready);
      chk("pipe_stall", pipe_stall, e_force);
      chk("gpr_WR", gpr_WR, e_wr);
      chk("gpr_mod_reg", gpr_mod_reg, e_rd);
      chk("gpr_in_data", gpr_in_data, e_data);
      chk("gpr_pc", gpr_pc, e_pc);
      chk("hazard", hazard, e_haz);

      if (e_head) begin
        busy[q[0].rd] = 0;
        void'(q.pop_front());
        starve = 0;
      end else if (q.size() > 0) begin
        starve = (starve < STARVE_LIMIT) ? starve + 1 : STARVE_LIMIT;
      end else begin
        starve = 0;
      end
      if (md_issue && md_issue_rd != 0) busy[md_issue_rd] = 1;
      if (md_valid && e_ready) q.push_back('{rd: md_rd, data: md_data, pc: md_pc});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    Reset = 1'b1;
    pipe_wr = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h33; pipe_pc = 32'h300;
    md_valid = 1'b1; md_rd = 5'd2; md_data = 32'h22; md_pc = 32'h200;
    md_issue = 1'b0; md_issue_rd = 5'd0; dec_rs = 5'd0; dec_rt = 5'd0;

    // Reset held two cycles with requests active
    settle();
    chk("reset_c1_md_ready", md_ready, 0);
    chk("reset_c1_gpr_WR", gpr_WR, 0);
    step(); settle();
    chk("reset_c2_md_ready", md_ready, 0);
    chk("reset_c2_stall", pipe_stall, 0);
    step();
    Reset = 1'b0; pipe_wr = 1'b0; md_valid = 1'b0;
    settle();
    chk("release_md_ready", md_ready, 1);
    chk("release_hazard", hazard, 0);
    chk("release_no_push", gpr_WR, 0);

    // Idle pipe: issue rd5, push result, write lands next cycle
    step(); md_issue = 1'b1; md_issue_rd = 5'd5; dec_rs = 5'd5;
    settle(); chk("idle_issue_hazard", hazard, 0);
    step(); md_issue = 1'b0; md_valid = 1'b1; md_rd = 5'd5; md_data = 32'h1234; md_pc = 32'h100;
    settle(); chk("idle_busy_hazard", hazard, 1); chk("idle_push_no_bypass", gpr_WR, 0);
    step(); md_valid = 1'b0;
    settle();
    chk("idle_wr", gpr_WR, 1);
    chk("idle_mod_reg", gpr_mod_reg, 5);
    chk("idle_data", gpr_in_data, 32'h1234);
    chk("idle_pc", gpr_pc, 32'h100);
    chk("idle_hazard_grant_cycle", hazard, 1);
    step(); settle();
    chk("idle_hazard_cleared", hazard, 0);
    dec_rs = 5'd0;

    // Contention: pipe rd7 continuous, one buffered rd9
    step();
    pipe_wr = 1'b1; pipe_rd = 5'd7; pipe_data = 32'h77; pipe_pc = 32'h700;
    md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h99; md_pc = 32'h900;
    settle(); chk("cont_c0_mod_reg", gpr_mod_reg, 7);
    for (int i = 1; i <= 5; i++) begin
      step(); md_valid = 1'b0; settle();
      if (i == 4) begin
        chk("cont_force_stall", pipe_stall, 1);
        chk("cont_force_mod_reg", gpr_mod_reg, 9);
        chk("cont_force_data", gpr_in_data, 32'h99);
      end else begin
        chk("cont_pipe_stall", pipe_stall, 0);
        chk("cont_pipe_mod_reg", gpr_mod_reg, 7);
      end
    end

    // Full FIFO under continuous pipe writes
    for (int k = 0; k <= 13; k++) begin
      step();
      pipe_wr = 1'b1; pipe_rd = 5'd8; pipe_data = 32'h800 + k; pipe_pc = 32'h8000 + k;
      md_valid = (k <= 5);
      if (k == 0)      begin md_rd = 5'd10; md_data = 32'hA0; md_pc = 32'hA00; end
      else if (k == 1) begin md_rd = 5'd11; md_data = 32'hA1; md_pc = 32'hA10; end
      else             begin md_rd = 5'd12; md_data = 32'hA2; md_pc = 32'hA20; end
      settle();
      case (k)
        2: chk("full_k2_md_ready", md_ready, 0);
        4: begin
          chk("full_k4_mod_reg", gpr_mod_reg, 10);
          chk("full_k4_stall", pipe_stall, 1);
          chk("full_k4_md_ready", md_ready, 0);
        end
        5: chk("full_k5_md_ready", md_ready, 1);
        8: chk("full_k8_mod_reg", gpr_mod_reg, 11);
        12: begin
          chk("full_k12_mod_reg", gpr_mod_reg, 12);
          chk("full_k12_data", gpr_in_data, 32'hA2);
        end
        13: chk("full_k13_stall", pipe_stall, 0);
        default: ;
      endcase
    end
    step(); pipe_wr = 1'b0; md_valid = 1'b0;
    settle(); chk("full_drained", gpr_WR, 0);

    // $0 handling
    step();
    md_issue = 1'b1; md_issue_rd = 5'd0;
    md_valid = 1'b1; md_rd = 5'd0; md_data = 32'hDEAD; md_pc = 32'hD00;
    settle(); chk("zero_issue_hazard", hazard, 0);
    step(); md_issue = 1'b0; md_valid = 1'b0;
    settle();
    chk("zero_md_wr", gpr_WR, 0);
    chk("zero_md_data", gpr_in_data, 32'hDEAD);
    chk("zero_busy0", hazard, 0);
    step(); pipe_wr = 1'b1; pipe_rd = 5'd0; pipe_data = 32'h55; pipe_pc = 32'h550;
    settle();
    chk("zero_pipe_wr", gpr_WR, 0);
    chk("zero_pipe_data", gpr_in_data, 32'h55);
    step(); pipe_wr = 1'b0;
    settle(); chk("zero_popped", gpr_in_data, 0);

    // Simultaneous set and clear of rd4
    step(); md_issue = 1'b1; md_issue_rd = 5'd4; dec_rt = 5'd4;
    settle(); chk("sc_first_issue_hazard", hazard, 0);
    step(); md_issue = 1'b0; md_valid = 1'b1; md_rd = 5'd4; md_data = 32'h44; md_pc = 32'h400;
    settle(); chk("sc_busy_hazard", hazard, 1);
    step(); md_valid = 1'b0; md_issue = 1'b1; md_issue_rd = 5'd4;
    settle();
    chk("sc_grant_wr", gpr_WR, 1);
    chk("sc_grant_mod_reg", gpr_mod_reg, 4);
    step(); md_issue = 1'b0;
    settle(); chk("sc_set_wins", hazard, 1);
    step(); md_valid = 1'b1; md_data = 32'h45;
    step(); md_valid = 1'b0;
    settle(); chk("sc_second_grant", gpr_in_data, 32'h45);
    step(); settle(); chk("sc_cleared", hazard, 0);
    dec_rt = 5'd0;

    // Reset mid-operation discards buffered results and busy bits
    step();
    md_issue = 1'b1; md_issue_rd = 5'd6;
    md_valid = 1'b1; md_rd = 5'd6; md_data = 32'h66; md_pc = 32'h600;
    pipe_wr = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h11; pipe_pc = 32'h110;
    step(); md_issue = 1'b0; md_rd = 5'd13; md_data = 32'hD; md_pc = 32'hD0;
    step(); md_valid = 1'b0; Reset = 1'b1; dec_rs = 5'd6;
    settle();
    chk("midrst_hazard", hazard, 0);
    chk("midrst_md_ready", md_ready, 0);
    chk("midrst_gpr_WR", gpr_WR, 0);
    step(); Reset = 1'b0; pipe_wr = 1'b0;
    settle();
    chk("midrst_release_ready", md_ready, 1);
    chk("midrst_release_wr", gpr_WR, 0);
    chk("midrst_release_hazard", hazard, 0);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpr_wb_arbiter.md
# gpr_wb_arbiter

Write-port arbiter and scoreboard for the single-write-port GPR in the pipelined CPU. It shares the GPR write port between the main pipeline's writeback stage and a long-latency multiply/divide unit, whose results are buffered in a small FIFO. It tracks destination registers with pending multiply/divide results and flags read-after-write and write-after-write hazards to the decode stage. A starvation counter ensures buffered results eventually reach the register file.

## Interface
Parameters:
- DEPTH, 2, multiply/divide result FIFO depth (1..4)
- STARVE_LIMIT, 3, cycles a FIFO head may lose arbitration before the pipeline is stalled

Ports:
- clk  input  1  clock; all state updates on posedge
- Reset  input  1  asynchronous, active-high reset
- pipe_wr  input  1  WB-stage write request
- pipe_rd  input  5  WB-stage destination register
- pipe_data  input  32  WB-stage write data
- pipe_pc  input  32  WB-stage PC, used for trace
- pipe_stall  output  1  WB must hold its write this cycle and re-present it next cycle
- md_issue  input  1  mul/div issued this cycle with a GPR destination
- md_issue_rd  input  5  destination of the issued operation
- md_valid  input  1  mul/div result available
- md_ready  output  1  FIFO can accept a result
- md_rd  input  5  result destination
- md_data  input  32  result data
- md_pc  input  32  PC of the originating instruction
- dec_rs, dec_rt  input  5 each  decode-stage source registers
- hazard  output  1  dec_rs, dec_rt or md_issue_rd is pending in the scoreboard
- gpr_WR  output  1  to GPR WR
- gpr_mod_reg  output  5  to GPR mod_reg
- gpr_in_data  output  32  to GPR in_data
- gpr_pc  output  32  to GPR programCounter

## Operation
- FIFO: push on posedge when md_valid && md_ready; md_ready = (count < DEPTH) && !Reset. No bypass: every result spends at least 1 cycle in the FIFO. A full FIFO with a simultaneous pop still deasserts md_ready for that cycle.
- Arbitration (combinational, per cycle):
  - force = FIFO nonempty && starve_cnt == STARVE_LIMIT.
  - If force: FIFO head wins, pipe_stall = 1, and the pipe write is ignored.
  - Else if pipe_wr: pipe wins, pipe_stall = 0.
  - Else if FIFO nonempty: head wins.
  - Else: no grant.
- Winner drives gpr_mod_reg, gpr_in_data and gpr_pc. gpr_WR = grant && winner rd != 0.
- A FIFO head with rd == 0 is still popped, with gpr_WR = 0.
- FIFO pops on posedge when the head wins.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - Cleared on a head grant or when the FIFO is empty.
  - Otherwise increments when the head loses, saturating at STARVE_LIMIT.
- Scoreboard, 32 busy bits, bit 0 hardwired to 0:
  - Set on md_issue for md_issue_rd.
  - Cleared when the FIFO head for that register is granted.
  - Same-cycle set and clear of the same register: set wins.
- hazard = busy[dec_rs] | busy[dec_rt] | (md_issue && busy[md_issue_rd]). It is purely combinational from the current busy bits. Decode must not issue while hazard is high, and a hazarded md_issue is dropped by decode; the block itself applies md_issue unconditionally.

## Timing
- Reset values: FIFO empty, count 0, busy all 0, starve_cnt 0; gpr_WR 0, gpr_mod_reg 0, gpr_in_data 0, gpr_pc 0, pipe_stall 0, hazard 0, md_ready 0 while Reset is high and 1 in the first cycle after release.
- Reset mid-operation discards buffered results and clears all busy bits.
- GPR outputs are combinational, so the GPR captures the winner at the same posedge that pops/consumes it.
- md result latency: push at edge N, earliest GPR write at edge N+1.
- Scoreboard clear is visible to hazard in the cycle after the granting edge. Decode therefore reads the GPR after its write has landed.
- Worst-case head wait: STARVE_LIMIT cycles of continuous pipe writes, then a forced grant on the next cycle.

## Test plan
- Reset: hold Reset for 2 cycles with md_valid=1 -> md_ready=0, gpr_WR=0, no push; after release md_ready=1 and hazard=0.
- Idle pipe: md_issue rd=5; push md result rd=5, data=0x1234 at edge N -> hazard on dec_rs=5 is 1 until the edge after N+1; gpr_WR=1, mod_reg=5, in_data=0x1234 in cycle N+1.
- Contention, STARVE_LIMIT=3: pipe_wr held 1 (rd=7) with one result (rd=9) buffered -> pipe wins for 3 cycles, then cycle 4 has pipe_stall=1 and mod_reg=9; pipe wins again in cycle 5.
- Full FIFO, DEPTH=2: push 2 results while the pipe writes continuously -> md_ready=0 until the first pop. A third md_valid is not accepted early and no data is lost or reordered.
- $0 handling: md result rd=0 and pipe_wr with rd=0 -> gpr_WR=0 both times, the FIFO entry is popped, and busy[0] stays 0 after md_issue rd=0.
- Simultaneous set and clear: md_issue rd=4 in the cycle the old rd=4 result is granted -> busy[4]=1 afterwards and hazard asserts for dec_rt=4.
